// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch counter and its display-mux top.
package stopwatch_pkg;
    localparam int BCD_DIGIT_W      = 4;
    localparam int NUM_DIGITS       = 4;
    localparam int BCD_MAX_DIGIT    = 9;
    localparam int COUNT_W          = BCD_DIGIT_W * NUM_DIGITS;
    localparam int TICK_DIV_DEFAULT = 100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;
endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the stopwatch count; carry_out feeds the next digit's inc.
// Clear wins over inc; the digit rolls 9 -> 0 while raising carry_out combinationally.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic                   i_w_clk,
    input  logic                   i_w_reset_n,
    input  logic                   i_w_clear,
    input  logic                   i_w_inc,
    output logic [BCD_DIGIT_W-1:0] o_r_digit,
    output logic                   o_w_carry_out
);
    localparam logic [BCD_DIGIT_W-1:0] MAX_DIGIT = BCD_DIGIT_W'(BCD_MAX_DIGIT);

    assign o_w_carry_out = i_w_inc && (o_r_digit == MAX_DIGIT);

    always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
        if (!i_w_reset_n) begin
            o_r_digit <= '0;
        end else if (i_w_clear) begin
            o_r_digit <= '0;
        end else if (i_w_inc) begin
            o_r_digit <= o_w_carry_out ? '0 : o_r_digit + 1'b1;
        end
    end
endmodule

// File: rtl/stopwatch_bcd_counter.sv
// 4-digit BCD stopwatch feeding the 7-segment mux; one increment per TICK_DIV cycles in RUN.
// Optional lap-freeze of the displayed value is built when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int PRESC_W  = 24
) (
    input  logic               i_w_clk,
    input  logic               i_w_reset_n,
    input  logic               i_w_start_stop,
    input  logic               i_w_clear,
    input  logic               i_w_lap,
    output logic [COUNT_W-1:0] o_r_digits,
    output logic               o_r_running,
    output logic               o_r_update,
    output logic               o_r_overflow
);
    localparam logic [PRESC_W-1:0]     PRESC_TC  = PRESC_W'(TICK_DIV - 1);
    localparam logic [BCD_DIGIT_W-1:0] MAX_DIGIT = BCD_DIGIT_W'(BCD_MAX_DIGIT);

    // Reset asserts asynchronously but is released in step with i_w_clk.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
        if (!i_w_reset_n) r_rst_sync <= '0;
        else              r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    state_t r_state, w_state_nxt;

    always_ff @(posedge i_w_clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_w_clear) begin
            w_state_nxt = ST_IDLE;
        end else if (i_w_start_stop) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_RUN;
                ST_RUN:   w_state_nxt = ST_PAUSE;
                ST_PAUSE: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;

    assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_TC) && !i_w_clear;

    always_ff @(posedge i_w_clk or negedge w_rst_n) begin
        if (!w_rst_n)                r_presc <= '0;
        else if (i_w_clear)          r_presc <= '0;
        else if (r_state == ST_RUN)  r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end

    logic [NUM_DIGITS:0]    w_inc;
    logic [BCD_DIGIT_W-1:0] w_digit [NUM_DIGITS];
    logic [COUNT_W-1:0]     w_count_nxt;

    assign w_inc[0] = w_tick;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .i_w_clk       (i_w_clk),
            .i_w_reset_n   (w_rst_n),
            .i_w_clear     (i_w_clear),
            .i_w_inc       (w_inc[g]),
            .o_r_digit     (w_digit[g]),
            .o_w_carry_out (w_inc[g+1])
        );
    end

    // Value the digit chain will hold after this edge, so the display moves on the same edge.
    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!w_inc[i])                  w_count_nxt[i*BCD_DIGIT_W +: BCD_DIGIT_W] = w_digit[i];
            else if (w_digit[i] != MAX_DIGIT) w_count_nxt[i*BCD_DIGIT_W +: BCD_DIGIT_W] = w_digit[i] + 1'b1;
        end
        if (i_w_clear) w_count_nxt = '0;
    end

    logic w_frozen_nxt;
`ifdef STOPWATCH_LAP_EN
    logic r_frozen;

    always_comb begin
        w_frozen_nxt = r_frozen;
        if (i_w_clear)                               w_frozen_nxt = 1'b0;
        else if (i_w_lap && r_state == ST_RUN)       w_frozen_nxt = !r_frozen;
        else if (i_w_lap && r_state == ST_PAUSE)     w_frozen_nxt = 1'b0;
    end

    always_ff @(posedge i_w_clk or negedge w_rst_n) begin
        if (!w_rst_n) r_frozen <= 1'b0;
        else          r_frozen <= w_frozen_nxt;
    end
`else
    logic w_unused_lap;
    assign w_unused_lap = i_w_lap;
    assign w_frozen_nxt = 1'b0;
`endif

    logic [COUNT_W-1:0] w_disp_nxt;
    assign w_disp_nxt = w_frozen_nxt ? o_r_digits : w_count_nxt;

    always_ff @(posedge i_w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            o_r_digits   <= '0;
            o_r_update   <= 1'b0;
            o_r_running  <= 1'b0;
            o_r_overflow <= 1'b0;
        end else begin
            o_r_digits   <= w_disp_nxt;
            o_r_update   <= (w_disp_nxt != o_r_digits);
            o_r_running  <= (w_state_nxt == ST_RUN);
            if (i_w_clear)              o_r_overflow <= 1'b0;
            else if (w_inc[NUM_DIGITS]) o_r_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: hand-derived vector table plus random pulses against a decimal model.
module tb_stopwatch_bcd_counter;
    localparam int TD = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, ss, clr, lap;
    logic [15:0] digits;
    logic        running, update, ovf;

    always #5 clk = ~clk;

    stopwatch_bcd_counter #(.TICK_DIV(TD), .PRESC_W(24)) dut (
        .i_w_clk        (clk),
        .i_w_reset_n    (rst_n),
        .i_w_start_stop (ss),
        .i_w_clear      (clr),
        .i_w_lap        (lap),
        .o_r_digits     (digits),
        .o_r_running    (running),
        .o_r_update     (update),
        .o_r_overflow   (ovf)
    );

    int n_pass  = 0;
    int n_total = 0;
    int upd_seen;

    // Reference model: mode 0 = cleared/idle, 1 = counting, 2 = paused; count is a plain integer.
    int m_mode, m_count, m_phase, m_shown;
    bit m_frozen, m_ovf, m_update, m_running;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_count = 0; m_phase = 0; m_shown = 0;
        m_frozen = 0; m_ovf = 0; m_update = 0; m_running = 0;
    endtask

    task automatic model_step(input bit s, input bit c, input bit l);
        int nxt;
        if (c) begin
            m_mode = 0; m_phase = 0; m_count = 0; m_ovf = 0; m_frozen = 0;
        end else begin
            if (m_mode == 1) begin
                if (m_phase == TD - 1) begin
                    m_phase = 0;
                    if (m_count == 9999) begin m_count = 0; m_ovf = 1; end
                    else m_count++;
                end else m_phase++;
            end
            if (LAP_EN && l) begin
                if (m_mode == 1)      m_frozen = !m_frozen;
                else if (m_mode == 2) m_frozen = 0;
            end
            if (s) m_mode = (m_mode == 1) ? 2 : 1;
        end
        nxt       = m_frozen ? m_shown : m_count;
        m_update  = (nxt != m_shown);
        m_shown   = nxt;
        m_running = (m_mode == 1);
    endtask

    // Called at a falling edge: drive, clock, then compare at the next falling edge.
    task automatic cyc(input bit s, input bit c, input bit l);
        ss = s; clr = c; lap = l;
        @(posedge clk);
        model_step(s, c, l);
        @(negedge clk);
        ss = 0; clr = 0; lap = 0;
        if (update) upd_seen++;
        check("model", int'({digits, running, update, ovf}),
              int'({to_bcd(m_shown), m_running, m_update, m_ovf}));
    endtask

    typedef struct {
        bit          ss;
        bit          clr;
        bit          lap;
        int          n;
        logic [15:0] digits;
        bit          running;
        bit          ovf;
        int          upd;
    } vec_t;

    vec_t tbl[21];

    initial begin
        tbl[0]  = '{0, 0, 0, 19,    16'h0000, 1'b0, 1'b0, 0};
        tbl[1]  = '{1, 0, 0, 40,    16'h0010, 1'b1, 1'b0, 10};
        tbl[2]  = '{1, 0, 0, 10,    16'h0010, 1'b0, 1'b0, 0};
        tbl[3]  = '{1, 0, 0, 3,     16'h0011, 1'b1, 1'b0, 1};
        tbl[4]  = '{0, 1, 0, 0,     16'h0000, 1'b0, 1'b0, 1};
        tbl[5]  = '{1, 0, 0, 3,     16'h0000, 1'b1, 1'b0, 0};
        tbl[6]  = '{1, 0, 0, 10,    16'h0001, 1'b0, 1'b0, 1};
        tbl[7]  = '{1, 0, 0, 3,     16'h0001, 1'b1, 1'b0, 0};
        tbl[8]  = '{0, 0, 0, 0,     16'h0002, 1'b1, 1'b0, 1};
        tbl[9]  = '{0, 0, 0, 387,   16'h0099, 1'b1, 1'b0, 97};
        tbl[10] = '{0, 0, 0, 3,     16'h0100, 1'b1, 1'b0, 1};
        tbl[11] = '{0, 0, 0, 39595, 16'h9999, 1'b1, 1'b0, 9899};
        tbl[12] = '{0, 0, 0, 3,     16'h0000, 1'b1, 1'b1, 1};
        tbl[13] = '{0, 0, 0, 3,     16'h0001, 1'b1, 1'b1, 1};
        tbl[14] = '{0, 0, 0, 487,   16'h0123, 1'b1, 1'b1, 122};
        tbl[15] = '{1, 1, 0, 0,     16'h0000, 1'b0, 1'b0, 1};
        tbl[16] = '{0, 0, 0, 9,     16'h0000, 1'b0, 1'b0, 0};
        tbl[17] = '{1, 0, 0, 20,    16'h0005, 1'b1, 1'b0, 5};
        tbl[18] = '{0, 0, 1, 19,    LAP_EN ? 16'h0005 : 16'h0010, 1'b1, 1'b0, LAP_EN ? 0 : 5};
        tbl[19] = '{0, 0, 1, 0,     16'h0010, 1'b1, 1'b0, LAP_EN ? 1 : 0};
        tbl[20] = '{0, 1, 1, 0,     16'h0000, 1'b0, 1'b0, 1};

        rst_n = 1'b0; ss = 0; clr = 0; lap = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_digits",  int'(digits),  0);
        check("rst_running", int'(running), 0);
        check("rst_update",  int'(update),  0);
        check("rst_ovf",     int'(ovf),     0);
        rst_n = 1'b1;
        repeat (3) cyc(0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            upd_seen = 0;
            cyc(tbl[i].ss, tbl[i].clr, tbl[i].lap);
            repeat (tbl[i].n) cyc(0, 0, 0);
            check($sformatf("row%0d_digits", i),  int'(digits),  int'(tbl[i].digits));
            check($sformatf("row%0d_running", i), int'(running), int'(tbl[i].running));
            check($sformatf("row%0d_ovf", i),     int'(ovf),     int'(tbl[i].ovf));
            check($sformatf("row%0d_updates", i), upd_seen,      tbl[i].upd);
        end

        // Random pulse traffic, including lap in every state and coincident commands.
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 11) == 0, $urandom_range(0, 149) == 0,
                $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset mid-run clears outputs without waiting for a clock edge.
        cyc(1, 0, 0);
        repeat (9) cyc(0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_digits",  int'(digits),  0);
        check("arst_running", int'(running), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (8) cyc(0, 0, 0);
        check("post_arst_digits", int'(digits), 16'h0002);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
